// File: rtl/fpadd_wb_pkg.sv
// Shared constants and helpers for the fpadd writeback/result-capture stage.
package fpadd_wb_pkg;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

    // Single-precision results live in [63:32] and are NaN-boxed into the low word.
    function automatic logic [63:0] fmt_result(input logic [63:0] res, input logic is_single);
        return is_single ? {NANBOX_HI, res[63:32]} : res;
    endfunction

endpackage

// File: rtl/fpadd_wb_fifo.sv
// Generic circular FIFO: separate occupancy counter, head visible combinationally.
module fpadd_wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full is judged on the registered count, so a same-cycle pop never admits a push.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fpadd_wb.sv
// fpadd writeback stage: formats results, queues them toward the register file,
// and accumulates the sticky exception flags.
module fpadd_wb
    import fpadd_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_result,
    input  logic [4:0]             in_flags,
    input  logic                   in_denorm,
    input  logic                   in_p,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_denorm,
    output logic [4:0]             fflags,
    input  logic                   fflags_wr,
    input  logic [4:0]             fflags_wdata,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             denorm;
    } wb_entry_t;

    wb_entry_t  w_in_entry;
    wb_entry_t  w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_push_flags;
    logic [4:0] r_fflags;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_in_entry.data   = fmt_result(in_result, in_p);
    assign w_in_entry.tag    = in_tag;
    assign w_in_entry.denorm = in_denorm;

    fpadd_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_data   = out_valid ? w_head.data   : '0;
    assign out_tag    = out_valid ? w_head.tag    : '0;
    assign out_denorm = out_valid ? w_head.denorm : 1'b0;

    always_comb begin
        w_push_flags         = '0;
        w_push_flags[FLG_NV] = w_push & in_flags[FLG_NV];
        w_push_flags[FLG_DZ] = w_push & in_flags[FLG_DZ];
        w_push_flags[FLG_OF] = w_push & in_flags[FLG_OF];
        w_push_flags[FLG_UF] = w_push & in_flags[FLG_UF];
        w_push_flags[FLG_NX] = w_push & in_flags[FLG_NX];
    end

    // A software write replaces the sticky value but still merges flags pushed this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fflags <= '0;
        else          r_fflags <= (fflags_wr ? fflags_wdata : r_fflags) | w_push_flags;
    end

    assign fflags = r_fflags;

endmodule
